// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, ALU ops,
// instruction fields and datapath mux selects.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_NOR = 3'b100
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in,
// ALU operation, mux selects and strobes out.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       ov;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       exc;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, ov, mem_ready,
    output alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, pc_write, pc_src, exc, state
  );

  modport slave (
    output opcode, funct, zero, ov, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, pc_write, pc_src, exc, state
  );
endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// R-type funct decode: ALU operation, legality, and whether overflow
// traps for this function (only add/sub are checked).
module alu_op_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal,
  output logic       ov_checked
);

  always_comb begin
    alu_op     = ALU_ADD;
    legal      = 1'b1;
    ov_checked = 1'b0;
    case (funct)
      FN_ADD: begin alu_op = ALU_ADD; ov_checked = 1'b1; end
      FN_SUB: begin alu_op = ALU_SUB; ov_checked = 1'b1; end
      FN_AND: alu_op = ALU_AND;
      FN_OR:  alu_op = ALU_OR;
      FN_NOR: alu_op = ALU_NOR;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute and
// drives ALU op, mux selects and strobes for the datapath.
//
// state     | meaning
// FETCH     | read instr at PC, PC+4; wait on mem_ready
// DECODE    | compute branch target, dispatch on opcode
// MEM_ADDR  | base + imm for lw/sw
// MEM_RD    | data read; wait on mem_ready
// MEM_WB    | load result to rt
// MEM_WR    | data write; wait on mem_ready
// EXEC_R    | R-type ALU op, overflow check for add/sub
// R_WB      | R-type result to rd
// BRANCH    | compare, take branch if zero
// ADDI_EXEC | rs + imm, overflow check
// ADDI_WB   | addi result to rt
// JUMP      | load jump target
// TRAP      | exception vector, one-cycle exc
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  state_e     state_q, state_d;
  logic [2:0] fn_alu_op;
  logic       fn_legal;
  logic       fn_ov_checked;

  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, pc_write;
  logic [1:0] pc_src;
  logic       exc;

  alu_op_decode u_alu_op_decode (
    .funct      (bus.funct),
    .alu_op     (fn_alu_op),
    .legal      (fn_legal),
    .ov_checked (fn_ov_checked)
  );

  // Strobes decode from the current state combinationally: FETCH/MEM_*
  // react to same-cycle mem_ready and BRANCH to same-cycle zero.
  always_comb begin
    state_d    = state_q;
    alu_op     = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    exc        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = fn_legal ? S_EXEC_R : S_TRAP;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = fn_alu_op;
        state_d   = (bus.ov && fn_ov_checked) ? S_TRAP : S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = bus.zero;
        state_d   = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = bus.ov ? S_TRAP : S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        exc      = 1'b1;
        pc_src   = PC_SRC_EXC;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign bus.alu_op     = alu_op;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.iord       = iord;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.exc        = exc;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expected control
// sequences are queued alongside stimulus and checked cycle by cycle.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  typedef struct packed {
    logic [5:0] opc;
    logic [5:0] fn;
    logic       zero;
    logic       ov;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aop;
    logic       sa;
    logic [1:0] sb;
    logic       iord, mrd, mwr, irw, rw, rdst, m2r, pcw;
    logic [1:0] pcs;
    logic       exc;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  stim_t stim_q[$];
  ctl_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_traps = 0;
  int    seen_traps = 0;
  int    cyc = 0;
  logic  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic ctl_t blank(input state_e st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'h22: return 3'b001;
      6'h24: return 3'b010;
      6'h25: return 3'b011;
      6'h27: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic rnd_bit();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  task automatic push(input stim_t s, input ctl_t c);
    stim_q.push_back(s);
    exp_q.push_back(c);
  endtask

  task automatic push_trap(input stim_t s);
    ctl_t c;
    c = blank(S_TRAP);
    c.exc = 1'b1;
    c.pcs = 2'b11;
    c.pcw = 1'b1;
    s.rdy = rnd_bit();
    push(s, c);
    exp_traps++;
  endtask

  // Reference: expected control per cycle for one instruction, wf/wm are
  // mem_ready-low cycles in fetch and in the data access.
  task automatic gen_instr(input logic [5:0] opc, input logic [5:0] fn, input int wf,
                           input int wm, input logic zb, input logic ob);
    stim_t s;
    ctl_t  c;
    logic  r_legal, arith;
    r_legal = (opc == 6'h00) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27});
    arith   = (fn == 6'h20) || (fn == 6'h22);
    s.opc = opc; s.fn = fn; s.zero = zb; s.ov = ob; s.rdy = 1'b0;
    c = blank(S_FETCH); c.mrd = 1'b1; c.sb = 2'b01;
    for (int i = 0; i < wf; i++) push(s, c);
    s.rdy = 1'b1; c.irw = 1'b1; c.pcw = 1'b1;
    push(s, c);
    s.rdy = rnd_bit(); c = blank(S_DECODE); c.sb = 2'b11;
    push(s, c);
    if (opc == 6'h23 || opc == 6'h2B) begin
      s.rdy = rnd_bit(); c = blank(S_MEM_ADDR); c.sa = 1'b1; c.sb = 2'b10;
      push(s, c);
      if (opc == 6'h23) begin
        c = blank(S_MEM_RD); c.mrd = 1'b1; c.iord = 1'b1;
      end else begin
        c = blank(S_MEM_WR); c.mwr = 1'b1; c.iord = 1'b1;
      end
      s.rdy = 1'b0;
      for (int i = 0; i < wm; i++) push(s, c);
      s.rdy = 1'b1;
      push(s, c);
      if (opc == 6'h23) begin
        s.rdy = rnd_bit(); c = blank(S_MEM_WB); c.rw = 1'b1; c.m2r = 1'b1;
        push(s, c);
      end
    end else if (r_legal) begin
      s.rdy = rnd_bit(); c = blank(S_EXEC_R); c.sa = 1'b1; c.aop = ref_alu(fn);
      push(s, c);
      if (ob && arith) push_trap(s);
      else begin
        s.rdy = rnd_bit(); c = blank(S_R_WB); c.rw = 1'b1; c.rdst = 1'b1;
        push(s, c);
      end
    end else if (opc == 6'h04) begin
      s.rdy = rnd_bit(); c = blank(S_BRANCH); c.sa = 1'b1; c.aop = 3'b001;
      c.pcs = 2'b01; c.pcw = zb;
      push(s, c);
    end else if (opc == 6'h08) begin
      s.rdy = rnd_bit(); c = blank(S_ADDI_EXEC); c.sa = 1'b1; c.sb = 2'b10;
      push(s, c);
      if (ob) push_trap(s);
      else begin
        s.rdy = rnd_bit(); c = blank(S_ADDI_WB); c.rw = 1'b1;
        push(s, c);
      end
    end else if (opc == 6'h02) begin
      s.rdy = rnd_bit(); c = blank(S_JUMP); c.pcs = 2'b10; c.pcw = 1'b1;
      push(s, c);
    end else begin
      push_trap(s);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t a;
    a.st = bus.state; a.aop = bus.alu_op; a.sa = bus.alu_src_a; a.sb = bus.alu_src_b;
    a.iord = bus.iord; a.mrd = bus.mem_read; a.mwr = bus.mem_write; a.irw = bus.ir_write;
    a.rw = bus.reg_write; a.rdst = bus.reg_dst; a.m2r = bus.mem_to_reg;
    a.pcw = bus.pc_write; a.pcs = bus.pc_src; a.exc = bus.exc;
    return a;
  endfunction

  // Monitor: one expected control word per active cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      ctl_t a, e;
      cyc++;
      a = sample();
      if (a.exc) seen_traps++;
      n_cmp++;
      if (a.pcw && a.mwr) begin
        n_bad++;
        $display("FAIL pcw_with_mwr cycle %0d: got both high, required not both", cyc);
      end
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL underflow cycle %0d: got state %0d, required no pending cycle", cyc, a.st);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL ctl cycle %0d: got st=%0d word=%h required st=%0d word=%h",
                   cyc, a.st, a, e.st, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    stim_t s;
    int    k;
    logic [5:0] fn_tab [5];
    logic [5:0] op_tab [7];
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27};
    op_tab = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};

    rst_n = 1'b0;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.ov = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 32'(S_FETCH));
    chk("rst_mem_read", 32'(bus.mem_read), 32'd1);
    chk("rst_strobes", {bus.iord, bus.mem_write, bus.ir_write, bus.reg_write,
                        bus.pc_write, bus.exc}, 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_pc_src", 32'(bus.pc_src), 32'd0);

    // Abort an lw while stalled in MEM_RD.
    @(negedge clk);
    rst_n = 1'b1; bus.opcode = 6'h23; bus.mem_ready = 1'b1;
    k = 0;
    while (bus.state != 4'(S_MEM_RD) && k < 10) begin
      @(posedge clk); #1; k++;
    end
    bus.mem_ready = 1'b0;
    chk("reach_mem_rd", 32'(bus.state), 32'(S_MEM_RD));
    @(posedge clk); #1;
    chk("stall_mem_rd", 32'(bus.state), 32'(S_MEM_RD));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_state", 32'(bus.state), 32'(S_FETCH));
    chk("abort_mem_read", 32'(bus.mem_read), 32'd1);
    chk("abort_iord", 32'(bus.iord), 32'd0);
    chk("abort_reg_write", 32'(bus.reg_write), 32'd0);
    @(posedge clk); #1;
    chk("abort_pc_write", 32'(bus.pc_write), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_hold", 32'(bus.state), 32'(S_FETCH));

    gen_instr(6'h00, 6'h20, 0, 0, 1'b0, 1'b0);
    gen_instr(6'h00, 6'h22, 0, 0, 1'b0, 1'b1);
    gen_instr(6'h23, 6'h00, 0, 2, 1'b0, 1'b0);
    gen_instr(6'h04, 6'h00, 0, 0, 1'b1, 1'b0);
    gen_instr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0);
    gen_instr(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);
    gen_instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b0);
    gen_instr(6'h00, 6'h24, 0, 0, 1'b0, 1'b1);
    gen_instr(6'h00, 6'h25, 1, 0, 1'b1, 1'b1);
    gen_instr(6'h00, 6'h27, 0, 0, 1'b0, 1'b0);
    gen_instr(6'h08, 6'h00, 0, 0, 1'b0, 1'b1);
    gen_instr(6'h08, 6'h00, 2, 0, 1'b0, 1'b0);
    gen_instr(6'h2B, 6'h00, 1, 2, 1'b0, 1'b0);
    gen_instr(6'h02, 6'h00, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      logic [5:0] opc, fn;
      opc = op_tab[$urandom_range(0, 6)];
      if (opc == 6'h3F) opc = 6'($urandom);
      fn = (($urandom & 32'd7) == 32'd0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
      gen_instr(opc, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                rnd_bit(), ($urandom & 32'd3) == 32'd0);
    end

    while (stim_q.size() > 0) begin
      @(posedge clk); #1;
      s = stim_q.pop_front();
      bus.opcode = s.opc; bus.funct = s.fn; bus.zero = s.zero; bus.ov = s.ov;
      bus.mem_ready = s.rdy;
      mon_en = 1'b1;
    end
    @(posedge clk); #1;
    mon_en = 1'b0;
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    chk("exc_count", 32'(seen_traps), 32'(exp_traps));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
